// File: rtl/mmio_seg_pkg.sv
`default_nettype none
// ============================================================================
// mmio_seg_pkg : register map, CTRL bit positions and seven-segment glyphs
// Rev 1.0
// ============================================================================
package mmio_seg_pkg;

  localparam logic [3:0] ADDR_DISP   = 4'h0;
  localparam logic [3:0] ADDR_SW     = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_MODE_BIT  = 1;
  localparam int CTRL_BLANK_LSB = 2;
  localparam int STATUS_CHG_BIT = 0;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_BIN = 1'b1
  } disp_mode_e;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_seg_io_sw_debounce.sv
`default_nettype none
// ============================================================================
// sw_debounce : two-flop synchroniser plus stability counter for a switch bus
// Rev 1.0
// ============================================================================
module sw_debounce #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             changed_o
);

  localparam int CNT_W = $clog2(CYCLES);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_differ;
  logic             w_accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any return to the accepted value restarts the count, so glitches never land.
  always_comb begin
    w_differ = (sync2_q != stable_q);
    w_accept = w_differ && (cnt_q == CNT_W'(CYCLES - 1));
    stable_d = stable_q;
    cnt_d    = '0;
    if (w_accept) begin
      stable_d = sync2_q;
    end else if (w_differ) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign stable_o  = stable_q;
  assign changed_o = w_accept;

endmodule
`default_nettype wire

// File: rtl/mmio_seg_io.sv
`default_nettype none
// ============================================================================
// mmio_seg_io : MMIO bridge to debounced switches and a multiplexed 7-seg display
// Rev 1.0
// ============================================================================
module mmio_seg_io #(
  parameter int N_DIGITS        = 4,
  parameter int SW_WIDTH        = 8,
  parameter int REFRESH_DIV     = 4096,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          io_addr,
  input  logic                io_write_en,
  input  logic [31:0]         io_write_data,
  output logic [31:0]         io_read_data,
  input  logic [SW_WIDTH-1:0] sw,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an
);

  import mmio_seg_pkg::*;

  localparam int DISP_W = 4 * N_DIGITS;
  localparam int CTRL_W = N_DIGITS + 2;
  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [DISP_W-1:0]   disp_q, disp_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                chg_q, chg_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic [SW_WIDTH-1:0] w_sw_stable;
  logic                w_sw_changed;
  logic                w_wr_disp, w_wr_ctrl, w_wr_status;
  logic                w_pre_wrap;
  logic [3:0]          w_nibble;
  logic                w_bit;
  logic                w_blank;
  logic                w_lit;
  logic [6:0]          w_glyph;

  sw_debounce #(
    .WIDTH  (SW_WIDTH),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk       (clk),
    .reset     (reset),
    .sw_i      (sw),
    .stable_o  (w_sw_stable),
    .changed_o (w_sw_changed)
  );

  generate
    if (DISP_W < 32) begin : g_wdata_unused
      logic w_unused_wdata;
      assign w_unused_wdata = ^io_write_data[31:DISP_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q <= '0;
      ctrl_q <= CTRL_W'(1);
      chg_q  <= 1'b0;
      pre_q  <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= SEG_OFF;
    end else begin
      disp_q <= disp_d;
      ctrl_q <= ctrl_d;
      chg_q  <= chg_d;
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  always_comb begin
    w_wr_disp   = io_write_en && (io_addr == ADDR_DISP);
    w_wr_ctrl   = io_write_en && (io_addr == ADDR_CTRL);
    w_wr_status = io_write_en && (io_addr == ADDR_STATUS);

    disp_d = w_wr_disp ? io_write_data[DISP_W-1:0] : disp_q;
    ctrl_d = w_wr_ctrl ? io_write_data[CTRL_W-1:0] : ctrl_q;

    // A change accepted in the same cycle as a clear must not be lost.
    chg_d = chg_q;
    if (w_wr_status && io_write_data[STATUS_CHG_BIT]) chg_d = 1'b0;
    if (w_sw_changed) chg_d = 1'b1;

    w_pre_wrap = (pre_q == PRE_W'(REFRESH_DIV - 1));
    pre_d      = w_pre_wrap ? '0 : pre_q + 1'b1;
    idx_d      = idx_q;
    if (w_pre_wrap) begin
      idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    w_nibble = '0;
    w_bit    = 1'b0;
    w_blank  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_nibble = disp_q[4*i +: 4];
        w_bit    = disp_q[i];
        w_blank  = ctrl_q[CTRL_BLANK_LSB + i];
      end
    end

    w_lit = ctrl_q[CTRL_EN_BIT] && !w_blank;
    if (disp_mode_e'(ctrl_q[CTRL_MODE_BIT]) == MODE_BIN) begin
      w_glyph = hex_to_seg({3'b000, w_bit});
    end else begin
      w_glyph = hex_to_seg(w_nibble);
    end

    for (int i = 0; i < N_DIGITS; i++) begin
      an_d[i] = !(w_lit && (idx_q == IDX_W'(i)));
    end
    seg_d = w_lit ? w_glyph : SEG_OFF;
  end

  always_comb begin
    case (io_addr)
      ADDR_DISP:   io_read_data = 32'(disp_q);
      ADDR_SW:     io_read_data = 32'(w_sw_stable);
      ADDR_CTRL:   io_read_data = 32'(ctrl_q);
      ADDR_STATUS: io_read_data = {31'b0, chg_q};
      default:     io_read_data = 32'b0;
    endcase
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_seg_io.sv
`default_nettype none
// ============================================================================
// tb_mmio_seg_io : randomized self-checking bench for mmio_seg_io
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mmio_seg_io;

  localparam int N   = 4;
  localparam int SWW = 8;
  localparam int DIV = 4;
  localparam int DEB = 8;

  localparam logic [6:0] HEX_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     io_addr;
  logic           io_write_en;
  logic [31:0]    io_write_data;
  logic [31:0]    io_read_data;
  logic [SWW-1:0] sw;
  logic [6:0]     seg;
  logic [N-1:0]   an;

  int n_checks = 0;
  int n_errors = 0;
  int k;

  logic [15:0]    m_disp;
  logic [5:0]     m_ctrl;
  logic           m_chg;
  logic [SWW-1:0] m_sw;

  mmio_seg_io #(
    .N_DIGITS        (N),
    .SW_WIDTH        (SWW),
    .REFRESH_DIV     (DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_addr       (io_addr),
    .io_write_en   (io_write_en),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .sw            (sw),
    .seg           (seg),
    .an            (an)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset was released.
  always @(posedge clk or posedge reset) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_an(input int kk);
    int d;
    d = ((kk - 1) / DIV) % N;
    if (m_ctrl[0] && !m_ctrl[2 + d]) return ~(4'b0001 << d);
    return 4'hF;
  endfunction

  function automatic logic [6:0] exp_seg(input int kk);
    int d;
    d = ((kk - 1) / DIV) % N;
    if (!(m_ctrl[0] && !m_ctrl[2 + d])) return 7'h7F;
    if (m_ctrl[1]) return m_disp[d] ? 7'h79 : 7'h40;
    return HEX_LUT[m_disp[4*d +: 4]];
  endfunction

  task automatic model_reset();
    m_disp = '0;
    m_ctrl = 6'h01;
    m_chg  = 1'b0;
    m_sw   = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    io_addr       = a;
    io_write_data = d;
    io_write_en   = 1'b1;
    @(negedge clk);
    io_write_en   = 1'b0;
    case (a)
      4'h0:    m_disp = d[15:0];
      4'h8:    m_ctrl = d[5:0];
      4'hC:    if (d[0]) m_chg = 1'b0;
      default: ;
    endcase
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    io_addr = a;
    #1;
    check_eq(tag, io_read_data, exp);
  endtask

  task automatic chk_disp(input int n);
    repeat (n) begin
      check_eq("an", 32'(an), 32'(exp_an(k)));
      check_eq("seg", 32'(seg), 32'(exp_seg(k)));
      @(negedge clk);
    end
  endtask

  task automatic chk_swregs();
    rd_chk("sw_read", 4'h4, 32'(m_sw));
    rd_chk("chg", 4'hC, 32'(m_chg));
  endtask

  // A value that is held for DEB+2 or more cycles is accepted exactly DEB+2
  // cycles after it is applied; holds of at most DEB-2 cycles never are.
  task automatic sw_phase(input logic [SWW-1:0] v, input int hold);
    sw = v;
    for (int t = 1; t <= hold; t++) begin
      @(negedge clk);
      if (t == DEB + 2 && v != m_sw) begin
        m_sw  = v;
        m_chg = 1'b1;
      end
      chk_swregs();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [SWW-1:0] v;
    logic [SWW-1:0] nv;

    reset         = 1'b1;
    io_addr       = 4'h0;
    io_write_en   = 1'b0;
    io_write_data = 32'h0;
    sw            = '0;
    model_reset();
    repeat (2) @(negedge clk);

    check_eq("rst_an", 32'(an), 32'hF);
    check_eq("rst_seg", 32'(seg), 32'h7F);
    rd_chk("rst_disp", 4'h0, 32'h0);
    rd_chk("rst_ctrl", 4'h8, 32'h1);
    rd_chk("rst_sw", 4'h4, 32'h0);
    rd_chk("rst_status", 4'hC, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk_disp(20);

    // Hex scan
    wr(4'h0, 32'h0000_00A5);
    @(negedge clk);
    chk_disp(20);

    // Reset mid-scan
    wr(4'h0, 32'h0000_1234);
    @(negedge clk);
    chk_disp(6);
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("mid_rst_an", 32'(an), 32'hF);
    check_eq("mid_rst_seg", 32'(seg), 32'h7F);
    rd_chk("mid_rst_disp", 4'h0, 32'h0);
    rd_chk("mid_rst_ctrl", 4'h8, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_disp(20);

    // Binary mode with blanking
    wr(4'h8, 32'h07);
    wr(4'h0, 32'h2);
    @(negedge clk);
    chk_disp(20);
    wr(4'h8, 32'h0B);
    @(negedge clk);
    chk_disp(20);
    wr(4'h8, 32'h00);
    @(negedge clk);
    chk_disp(8);

    // Debounce: clean change, then a short glitch
    sw_phase(8'h5A, 12);
    wr(4'hC, 32'h1);
    chk_swregs();
    sw_phase(8'hC3, 5);
    sw_phase(8'h5A, 6);

    // Clear racing an accepted change
    wr(4'hC, 32'h1);
    chk_swregs();
    nv = ~m_sw;
    sw = nv;
    repeat (DEB + 1) @(negedge clk);
    wr(4'hC, 32'h1);
    m_sw  = nv;
    m_chg = 1'b1;
    chk_swregs();
    wr(4'hC, 32'h1);
    chk_swregs();
    wr(4'hC, 32'h0);
    chk_swregs();

    // Address decode
    wr(4'h8, 32'h1);
    wr(4'h0, 32'h0000_BEEF);
    wr(4'h4, 32'hFFFF_FFFF);
    wr(4'hE, 32'hFFFF_FFFF);
    rd_chk("addr_e", 4'hE, 32'h0);
    rd_chk("addr_1", 4'h1, 32'h0);
    rd_chk("addr_disp", 4'h0, 32'(m_disp));
    rd_chk("addr_ctrl", 4'h8, 32'(m_ctrl));
    chk_swregs();
    @(negedge clk);
    chk_disp(16);

    // Random display writes
    for (int i = 0; i < 12; i++) begin
      wr(4'h0, $urandom);
      wr(4'h8, $urandom);
      rd_chk("rnd_disp", 4'h0, 32'(m_disp));
      rd_chk("rnd_ctrl", 4'h8, 32'(m_ctrl));
      @(negedge clk);
      chk_disp($urandom_range(3, 20));
    end

    // Random switch activity
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        wr(4'hC, 32'h1);
        chk_swregs();
      end
      v = SWW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        sw_phase(v, $urandom_range(1, DEB - 2));
        sw_phase(m_sw, 3);
      end else begin
        sw_phase(v, DEB + 2 + $urandom_range(0, 3));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
